// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase scheduler: tick-timed greens with min/max and gap-out,
// yellow and all-red clearance, optional pedestrian walk phase enabled by `define TLC_PED_EN.
module intersection_phase_scheduler #(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int PED_T     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic       ped_walk,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALLRED_EW = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_NS = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] GMIN_L   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_L   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_L = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] PED_L    = CNT_W'(PED_T - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             nextNs_q, nextNs_d;
  logic             pedPending;

`ifdef TLC_PED_EN
  logic pedPending_q, pedPending_d, pedAck_q, enterWalk;

  assign pedPending   = pedPending_q;
  assign enterWalk    = (state_d == PED_WALK) && (state_q != PED_WALK);
  // A new request in the entry cycle outranks the clear, so it is served next time round.
  assign pedPending_d = ped_req | (pedPending_q & ~enterWalk);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pedPending_q <= 1'b0;
      pedAck_q     <= 1'b0;
    end else begin
      pedPending_q <= pedPending_d;
      pedAck_q     <= enterWalk;
    end
  end

  assign ped_ack  = pedAck_q;
  assign ped_walk = (state_q == PED_WALK);
`else
  logic unusedPed;
  assign unusedPed  = ped_req ^ (^PED_L);
  assign pedPending = 1'b0;
  assign ped_ack    = 1'b0;
  assign ped_walk   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    nextNs_d = nextNs_q;
    case (state_q)
      ALLRED_EW: if (tick && timer_q == ALLRED_L) begin
        state_d  = pedPending ? PED_WALK : NS_GREEN;
        nextNs_d = 1'b1;
      end
      NS_GREEN: if (tick && ((timer_q >= GMIN_L && (ew_car || pedPending)) || timer_q == GMAX_L))
        state_d = NS_YELLOW;
      NS_YELLOW: if (tick && timer_q == YELLOW_L) state_d = ALLRED_NS;
      ALLRED_NS: if (tick && timer_q == ALLRED_L) begin
        state_d  = pedPending ? PED_WALK : EW_GREEN;
        nextNs_d = 1'b0;
      end
      EW_GREEN: if (tick && ((timer_q >= GMIN_L && (ns_car || pedPending)) || timer_q == GMAX_L))
        state_d = EW_YELLOW;
      EW_YELLOW: if (tick && timer_q == YELLOW_L) state_d = ALLRED_EW;
`ifdef TLC_PED_EN
      PED_WALK: if (tick && timer_q == PED_L) state_d = nextNs_q ? NS_GREEN : EW_GREEN;
`endif
      default: state_d = ALLRED_EW;
    endcase

    // Timer restarts on every state change, including illegal-state recovery.
    if (state_d != state_q) timer_d = '0;
    else if (tick)          timer_d = timer_q + 1'b1;
    else                    timer_d = timer_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ALLRED_EW;
      timer_q  <= '0;
      nextNs_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      nextNs_q <= nextNs_d;
    end
  end

  assign ns_green  = (state_q == NS_GREEN);
  assign ns_yellow = (state_q == NS_YELLOW);
  assign ns_red    = ~(ns_green | ns_yellow);
  assign ew_green  = (state_q == EW_GREEN);
  assign ew_yellow = (state_q == EW_YELLOW);
  assign ew_red    = ~(ew_green | ew_yellow);
  assign phase     = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed self-checking bench for intersection_phase_scheduler with short test durations;
// pedestrian scenarios run when TLC_PED_EN is defined, the ignored-request scenario otherwise.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset, tick, ns_car, ew_car, ped_req;
  logic       ped_ack, ped_walk;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;

  intersection_phase_scheduler #(
    .CNT_W(8), .GREEN_MIN(4), .GREEN_MAX(8), .YELLOW_T(2), .ALLRED_T(1), .PED_T(3)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .ns_car(ns_car), .ew_car(ew_car),
    .ped_req(ped_req), .ped_ack(ped_ack), .ped_walk(ped_walk),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] lampsFor(input int ph);
    logic nsG, nsY, ewG, ewY;
    nsG = (ph == 1); nsY = (ph == 2);
    ewG = (ph == 4); ewY = (ph == 5);
    return {~(nsG | nsY), nsY, nsG, ~(ewG | ewY), ewY, ewG};
  endfunction

  // Checks one cycle's outputs, then advances to 1 time unit past the next rising edge.
  task automatic expectPhase(input string tag, input int ph, input int cycles, input logic ackFirst);
    for (int c = 0; c < cycles; c++) begin
      checkOutput({tag, ".phase"}, {5'd0, phase}, ph[7:0]);
      checkOutput({tag, ".lamps"}, {2'd0, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green},
                  {2'd0, lampsFor(ph)});
      checkOutput({tag, ".walk"}, {7'd0, ped_walk}, {7'd0, ph == 6});
      checkOutput({tag, ".ack"}, {7'd0, ped_ack}, {7'd0, ackFirst && c == 0});
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input logic nsCar, input logic ewCar, input logic pedReq);
    ns_car  = nsCar;
    ew_car  = ewCar;
    ped_req = pedReq;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.phase", {5'd0, phase}, 8'd0);
    checkOutput("rst.lamps", {2'd0, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}, 8'b0010_0100);
    checkOutput("rst.ack", {7'd0, ped_ack}, 8'd0);
    checkOutput("rst.walk", {7'd0, ped_walk}, 8'd0);
    reset = 1'b0;
  endtask

  task automatic fullCycle(input string tag);
    expectPhase(tag, 0, 1, 1'b0);
    expectPhase(tag, 1, 8, 1'b0);
    expectPhase(tag, 2, 2, 1'b0);
    expectPhase(tag, 3, 1, 1'b0);
    expectPhase(tag, 4, 8, 1'b0);
    expectPhase(tag, 5, 2, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    tick  = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // No demand: maximum greens, fixed rotation.
    applyReset();
    fullCycle("idle1");
    fullCycle("idle2");

    // East-west demand gaps out north-south at minimum green.
    applyReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectPhase("ewcar", 0, 1, 1'b0);
    expectPhase("ewcar", 1, 4, 1'b0);
    expectPhase("ewcar", 2, 2, 1'b0);
    expectPhase("ewcar", 3, 1, 1'b0);
    expectPhase("ewcar", 4, 8, 1'b0);
    expectPhase("ewcar", 5, 2, 1'b0);
    expectPhase("ewcar", 0, 1, 1'b0);
    expectPhase("ewcar", 1, 4, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Tick frozen mid north-south green, then resumes with remaining ticks.
    applyReset();
    expectPhase("frz", 0, 1, 1'b0);
    expectPhase("frz", 1, 3, 1'b0);
    tick = 1'b0;
    expectPhase("frz.hold", 1, 20, 1'b0);
    tick = 1'b1;
    expectPhase("frz", 1, 5, 1'b0);
    expectPhase("frz", 2, 2, 1'b0);
    expectPhase("frz", 3, 1, 1'b0);
    expectPhase("frz", 4, 2, 1'b0);

`ifdef TLC_PED_EN
    // Pedestrian request in second cycle of north-south green.
    applyReset();
    expectPhase("ped", 0, 1, 1'b0);
    expectPhase("ped", 1, 1, 1'b0);
    ped_req = 1'b1;
    expectPhase("ped", 1, 1, 1'b0);
    ped_req = 1'b0;
    expectPhase("ped", 1, 2, 1'b0);
    expectPhase("ped", 2, 2, 1'b0);
    expectPhase("ped", 3, 1, 1'b0);
    expectPhase("ped.walk", 6, 3, 1'b1);
    expectPhase("ped", 4, 8, 1'b0);
    expectPhase("ped", 5, 2, 1'b0);
    expectPhase("ped", 0, 1, 1'b0);
    expectPhase("ped", 1, 2, 1'b0);
`else
    // Requests ignored without the pedestrian feature.
    applyReset();
    ped_req = 1'b1;
    fullCycle("noped");
    ped_req = 1'b0;
`endif

    // Asynchronous reset in east-west green with a request pending.
    applyReset();
    expectPhase("arst", 0, 1, 1'b0);
    expectPhase("arst", 1, 8, 1'b0);
    expectPhase("arst", 2, 2, 1'b0);
    expectPhase("arst", 3, 1, 1'b0);
    ped_req = 1'b1;
    expectPhase("arst", 4, 1, 1'b0);
    ped_req = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("arst.phase", {5'd0, phase}, 8'd0);
    checkOutput("arst.nsred", {7'd0, ns_red}, 8'd1);
    checkOutput("arst.ewred", {7'd0, ew_red}, 8'd1);
    checkOutput("arst.ewgreen", {7'd0, ew_green}, 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    expectPhase("arst.post", 0, 1, 1'b0);
    expectPhase("arst.post", 1, 8, 1'b0);
    expectPhase("arst.post", 2, 2, 1'b0);
    expectPhase("arst.post", 3, 1, 1'b0);
    expectPhase("arst.post", 4, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
